// File: rtl/core_top.sv
`default_nettype none
// ============================================================================
// Module      : core_top
// Description : Single-issue fetch/execute core for a small variable-length
//               big-endian instruction subset (MOV imm, MOV reg, NOP, HLT).
//               It fetches 16 bytes per instruction and executes each
//               instruction in one cycle. The data port is tied off.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Register file: 16 x 16-bit, one write port, one combinational read port
// ----------------------------------------------------------------------------
module core_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [3:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] registers [16];

    // Synchronous clear on reset, otherwise a single write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                registers[i] <= 16'h0000;
            end
        end else if (we) begin
            registers[waddr] <= wdata;
        end
    end

    assign rdata = registers[raddr];

endmodule

// ----------------------------------------------------------------------------
// Core
// ----------------------------------------------------------------------------
module core_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    output logic [31:0]  mem_if_addr,
    output logic         mem_if_req,
    input  logic [127:0] mem_if_rdata,
    input  logic         mem_if_ack,
    output logic [31:0]  mem_data_addr,
    output logic [31:0]  mem_data_wdata,
    output logic [1:0]   mem_data_size,
    output logic         mem_data_we,
    output logic         mem_data_req,
    input  logic [31:0]  mem_data_rdata,
    input  logic         mem_data_ack,
    output logic         halted,
    output logic [31:0]  current_pc,
    output logic         dual_issue_active
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [15:0] c_OP_MOV_IMM = 16'h0009;
    localparam logic [15:0] c_OP_MOV_REG = 16'h0209;
    localparam logic [15:0] c_OP_NOP     = 16'h0000;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_halted;
    logic         w_halted_nxt;
    logic [127:0] r_ir;
    logic [127:0] w_ir_nxt;

    logic         w_rf_we;
    logic [3:0]   w_rf_waddr;
    logic [15:0]  w_rf_wdata;
    logic [15:0]  w_rf_rdata;

    // Instruction fields, big-endian: byte0 in the top byte of the fetch word
    logic [15:0]  w_specop;
    logic [3:0]   w_rd;
    logic [3:0]   w_rn;
    logic [15:0]  w_imm;

    assign w_specop = r_ir[127:112];
    assign w_rd     = r_ir[107:104];   // low nibble of byte2
    assign w_rn     = r_ir[99:96];     // low nibble of byte3
    assign w_imm    = r_ir[103:88];    // bytes 3..4

    core_regfile regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (w_rf_we),
        .waddr (w_rf_waddr),
        .wdata (w_rf_wdata),
        .raddr (w_rn),
        .rdata (w_rf_rdata)
    );

    // Architectural state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_ir     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= w_halted_nxt;
            r_ir     <= w_ir_nxt;
        end
    end

    // Next-state, decode and register-write control
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_halted_nxt = r_halted;
        w_ir_nxt     = r_ir;
        w_rf_we      = 1'b0;
        w_rf_waddr   = w_rd;
        w_rf_wdata   = 16'h0000;
        case (r_state)
            S_FETCH: begin
                // Only reached while the request is visible, so a stray ack
                // outside FETCH is never consumed.
                if (mem_if_ack) begin
                    w_ir_nxt    = mem_if_rdata;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                case (w_specop)
                    c_OP_MOV_IMM: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_imm;
                        w_pc_nxt   = r_pc + 32'd5;
                    end
                    c_OP_MOV_REG: begin
                        // Read port sees the pre-write value of R[rn]
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_rf_rdata;
                        w_pc_nxt   = r_pc + 32'd4;
                    end
                    c_OP_NOP: begin
                        w_pc_nxt   = r_pc + 32'd2;
                    end
                    default: begin
                        // HLT and every unrecognised encoding stop the core
                        // with the PC left on the offending instruction.
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = S_HALT;
                    end
                endcase
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Request is suppressed while reset is held so nothing is issued early
    assign mem_if_req  = (r_state == S_FETCH) && !rst;
    assign mem_if_addr = r_pc;

    assign halted            = r_halted;
    assign current_pc        = r_pc;
    assign dual_issue_active = 1'b0;

    // Data port is not used by this instruction subset
    assign mem_data_addr  = 32'h0000_0000;
    assign mem_data_wdata = 32'h0000_0000;
    assign mem_data_size  = 2'd0;
    assign mem_data_we    = 1'b0;
    assign mem_data_req   = 1'b0;

    logic w_unused_inputs;
    assign w_unused_inputs = ^{mem_data_rdata, mem_data_ack, r_ir[87:0], r_ir[111:108], r_ir[103:100]};

endmodule

`default_nettype wire

// File: tb/tb_core_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_top
// Description : Directed self-checking bench for core_top. A byte-array
//               instruction memory answers fetches with a programmable ack
//               latency; expected fetch addresses are queued per program and
//               popped as the core issues requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_top;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NO_STOP = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  mem_if_addr;
    logic         mem_if_req;
    logic [127:0] mem_if_rdata = '0;
    logic         mem_if_ack = 1'b0;
    logic [31:0]  mem_data_addr;
    logic [31:0]  mem_data_wdata;
    logic [1:0]   mem_data_size;
    logic         mem_data_we;
    logic         mem_data_req;
    logic [31:0]  mem_data_rdata = 32'hA5A5_A5A5;
    logic         mem_data_ack = 1'b0;
    logic         halted;
    logic [31:0]  current_pc;
    logic         dual_issue_active;

    core_top #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_if_addr       (mem_if_addr),
        .mem_if_req        (mem_if_req),
        .mem_if_rdata      (mem_if_rdata),
        .mem_if_ack        (mem_if_ack),
        .mem_data_addr     (mem_data_addr),
        .mem_data_wdata    (mem_data_wdata),
        .mem_data_size     (mem_data_size),
        .mem_data_we       (mem_data_we),
        .mem_data_req      (mem_data_req),
        .mem_data_rdata    (mem_data_rdata),
        .mem_data_ack      (mem_data_ack),
        .halted            (halted),
        .current_pc        (current_pc),
        .dual_issue_active (dual_issue_active)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [64];
    logic [31:0] exp_addr_q [$];
    int          checks = 0;
    int          errors = 0;
    logic        pending;
    logic [31:0] laddr;
    int          cnt;
    logic        stable_bad;
    logic        data_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fetch16(input logic [31:0] a);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) begin
            v[127 - 8*k -: 8] = mem[(a + k) & 32'd63];
        end
        return v;
    endfunction

    task automatic clear_mem();
        // Unprogrammed bytes decode as illegal, so any overrun halts the core
        for (int k = 0; k < 64; k++) mem[k] = 8'hFF;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] exp [16]);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_R%0d", tag, i), {16'h0, dut.regfile.registers[i]}, {16'h0, exp[i]});
        end
    endtask

    // Reset with a stray ack held high throughout; it must never be consumed
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        mem_if_ack   = 1'b1;
        mem_if_rdata = {8'h00, 8'h09, 8'h03, 8'h12, 8'h34, 88'h0};
        @(negedge clk);
        check("req_during_rst", {31'b0, mem_if_req}, 32'd0);
        @(negedge clk);
        check("req_during_rst2", {31'b0, mem_if_req}, 32'd0);
        check("pc_after_rst", current_pc, RESET_PC);
        check("halted_after_rst", {31'b0, halted}, 32'd0);
        check("R3_stray_ack", {16'h0, dut.regfile.registers[3]}, 32'd0);
        rst        = 1'b0;
        mem_if_ack = 1'b0;
        pending    = 1'b0;
        cnt        = 0;
        stable_bad = 1'b0;
        data_bad   = 1'b0;
        exp_addr_q.delete();
    endtask

    // Serve fetches with the given ack latency until halt, stop_pc or budget
    task automatic run(input int lat, input int budget, input logic [31:0] stop_pc, input string tag);
        logic done;
        done = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            mem_if_ack = 1'b0;
            if (mem_data_req || mem_data_we || dual_issue_active || mem_data_addr != 0 ||
                mem_data_wdata != 0 || mem_data_size != 0)
                data_bad = 1'b1;
            if (halted || current_pc == stop_pc) begin
                done = 1'b1;
                break;
            end
            if (mem_if_req) begin
                if (!pending) begin
                    pending = 1'b1;
                    laddr   = mem_if_addr;
                    cnt     = lat;
                    check({tag, "_fetch_expected"}, {31'b0, exp_addr_q.size() != 0}, 32'd1);
                    if (exp_addr_q.size() != 0)
                        check({tag, "_fetch_addr"}, mem_if_addr, exp_addr_q.pop_front());
                end else begin
                    if (mem_if_addr !== laddr) stable_bad = 1'b1;
                    cnt--;
                    if (cnt <= 0) begin
                        mem_if_ack   = 1'b1;
                        mem_if_rdata = fetch16(laddr);
                        pending      = 1'b0;
                    end
                end
            end
        end
        check({tag, "_finished_in_budget"}, {31'b0, done}, 32'd1);
    endtask

    task automatic finish_checks(input string tag);
        check({tag, "_all_fetches_seen"}, exp_addr_q.size(), 32'd0);
        check({tag, "_req_addr_stable"}, {31'b0, stable_bad}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_req_low_when_halted"}, {31'b0, mem_if_req}, 32'd0);
        end
        check({tag, "_data_port_idle"}, {31'b0, data_bad}, 32'd0);
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h09; mem[2] = 8'h01; mem[3] = 8'h00; mem[4] = 8'h05;
        mem[5] = 8'h02; mem[6] = 8'h09; mem[7] = 8'h02; mem[8] = 8'h01;
        mem[9] = 8'h00; mem[10] = 8'h12;
    endtask

    logic [15:0] exp_regs [16];

    initial begin
        // ---- Program 1, ack latency 1 ----
        load_prog1();
        do_reset();
        exp_addr_q = '{32'd0, 32'd5, 32'd9};
        run(1, 20, c_NO_STOP, "p1_lat1");
        for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;
        exp_regs[1] = 16'h0005; exp_regs[2] = 16'h0005;
        check_regs("p1_lat1", exp_regs);
        check("p1_lat1_pc", current_pc, 32'h0000_0009);
        check("p1_lat1_halted", {31'b0, halted}, 32'd1);
        finish_checks("p1_lat1");

        // ---- Program 1, ack latency 3 ----
        do_reset();
        exp_addr_q = '{32'd0, 32'd5, 32'd9};
        run(3, 40, c_NO_STOP, "p1_lat3");
        check_regs("p1_lat3", exp_regs);
        check("p1_lat3_pc", current_pc, 32'h0000_0009);
        check("p1_lat3_halted", {31'b0, halted}, 32'd1);
        finish_checks("p1_lat3");

        // ---- MOV R15, 0xBEEF ; HLT ----
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h09; mem[2] = 8'h0F; mem[3] = 8'hBE; mem[4] = 8'hEF;
        mem[5] = 8'h00; mem[6] = 8'h12;
        do_reset();
        exp_addr_q = '{32'd0, 32'd5};
        run(1, 20, c_NO_STOP, "p3");
        for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;
        exp_regs[15] = 16'hBEEF;
        check_regs("p3", exp_regs);
        check("p3_pc", current_pc, 32'h0000_0005);
        check("p3_halted", {31'b0, halted}, 32'd1);
        finish_checks("p3");

        // ---- Illegal FF FF at 0 ----
        clear_mem();
        do_reset();
        exp_addr_q = '{32'd0};
        run(2, 20, c_NO_STOP, "ill");
        for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;
        check_regs("ill", exp_regs);
        check("ill_pc", current_pc, 32'h0000_0000);
        check("ill_halted", {31'b0, halted}, 32'd1);
        finish_checks("ill");

        // ---- NOP, upper-nibble masking, MOV reg ----
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h00;
        mem[2] = 8'h00; mem[3] = 8'h09; mem[4] = 8'hF3; mem[5] = 8'h12; mem[6] = 8'h34;
        mem[7] = 8'h02; mem[8] = 8'h09; mem[9] = 8'hA4; mem[10] = 8'h53;
        mem[11] = 8'h00; mem[12] = 8'h12;
        do_reset();
        exp_addr_q = '{32'd0, 32'd2, 32'd7, 32'd11};
        run(1, 30, c_NO_STOP, "nop");
        for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;
        exp_regs[3] = 16'h1234; exp_regs[4] = 16'h1234;
        check_regs("nop", exp_regs);
        check("nop_pc", current_pc, 32'h0000_000B);
        check("nop_halted", {31'b0, halted}, 32'd1);
        finish_checks("nop");

        // ---- Reset after first MOV, then full rerun ----
        load_prog1();
        do_reset();
        exp_addr_q = '{32'd0, 32'd5, 32'd9};
        run(1, 20, 32'd5, "mid");
        check("mid_R1_before_rst", {16'h0, dut.regfile.registers[1]}, 32'h0000_0005);
        do_reset();
        for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;
        check_regs("mid_rst", exp_regs);
        check("mid_rst_pc", current_pc, 32'h0000_0000);
        check("mid_rst_halted", {31'b0, halted}, 32'd0);
        exp_addr_q = '{32'd0, 32'd5, 32'd9};
        run(1, 20, c_NO_STOP, "rerun");
        exp_regs[1] = 16'h0005; exp_regs[2] = 16'h0005;
        check_regs("rerun", exp_regs);
        check("rerun_pc", current_pc, 32'h0000_0009);
        check("rerun_halted", {31'b0, halted}, 32'd1);
        finish_checks("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
